// File: rtl/riscv_pkg.sv
// Shared constants and types for the single-cycle RV32I core.
// Included first so the regfile and the core can both import it.
package riscv_pkg;

    localparam int InstAddrBus = 32;
    localparam int InstBus     = 32;
    localparam int MemAddrBus  = 32;
    localparam int MemBus      = 32;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASS_B
    } alu_op_e;

    typedef enum logic [1:0] {
        WB_ALU, WB_LOAD, WB_PC4
    } wb_sel_e;

    // alt is instruction bit 30: selects SUB / SRA(I) where it applies.
    function automatic alu_op_e alu_op_from(input logic [2:0] f3, input logic alt);
        case (f3)
            F3_ADD:  return alt ? ALU_SUB : ALU_ADD;
            F3_SLL:  return ALU_SLL;
            F3_SLT:  return ALU_SLT;
            F3_SLTU: return ALU_SLTU;
            F3_XOR:  return ALU_XOR;
            F3_SR:   return alt ? ALU_SRA : ALU_SRL;
            F3_OR:   return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/riscv_regfile.sv
// 32x32 integer register file: two asynchronous read ports, one write port.
// x0 always reads zero and ignores writes.
module riscv_regfile
    import riscv_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata,
    input  logic [4:0]  raddr_a,
    output logic [31:0] rdata_a,
    input  logic [4:0]  raddr_b,
    output logic [31:0] rdata_b
);

    logic [31:0] regs [0:31];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (waddr != 5'd0)) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata_a = (raddr_a == 5'd0) ? 32'd0 : regs[raddr_a];
    assign rdata_b = (raddr_b == 5'd0) ? 32'd0 : regs[raddr_b];

endmodule

// File: rtl/riscv_ic_core.sv
// Single-cycle RV32I core: fetch, decode, execute and memory access settle
// within one clock; PC and the register write commit on the rising edge.
module riscv_ic_core
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        ibus_req_o,
    output logic [31:0] ibus_addr_o,
    input  logic [31:0] ibus_data_i,
    output logic        dbus_req_o,
    output logic        dbus_we_o,
    output logic [31:0] dbus_addr_o,
    input  logic [31:0] dbus_data_i,
    output logic [31:0] dbus_data_o,
    output logic [3:0]  dbus_sel_o,
    input  logic [7:0]  int_i
);

    // rst_n is the historical port name; it is active-high and asynchronous.
    logic        int_unused;
    logic [31:0] pc_q, pc_plus4, next_pc;
    logic [31:0] inst, rs1_val, rs2_val;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [31:0] alu_a, alu_b, alu_y, wb_data, load_val;
    logic [31:0] st_data;
    logic [3:0]  st_sel;
    logic [6:0]  opcode;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic        rd_we, mem_req, mem_we, br_taken, is_jalr, is_jal, is_branch;
    alu_op_e     alu_op;
    wb_sel_e     wb_sel;

    assign int_unused = ^int_i;

    assign inst     = ibus_data_i;
    assign opcode   = inst[6:0];
    assign rd       = inst[11:7];
    assign f3       = inst[14:12];
    assign rs1      = inst[19:15];
    assign rs2      = inst[24:20];
    assign pc_plus4 = pc_q + 32'd4;

    assign imm_i = {{20{inst[31]}}, inst[31:20]};
    assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    assign imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    assign imm_u = {inst[31:12], 12'd0};
    assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

    riscv_regfile u_regfile (
        .clk     (clk),
        .rst     (rst_n),
        .we      (rd_we),
        .waddr   (rd),
        .wdata   (wb_data),
        .raddr_a (rs1),
        .rdata_a (rs1_val),
        .raddr_b (rs2),
        .rdata_b (rs2_val)
    );

    always_comb begin
        alu_a     = rs1_val;
        alu_b     = imm_i;
        alu_op    = ALU_ADD;
        rd_we     = 1'b0;
        wb_sel    = WB_ALU;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        is_jal    = 1'b0;
        is_jalr   = 1'b0;
        is_branch = 1'b0;
        case (opcode)
            OPC_LUI: begin
                alu_op = ALU_PASS_B;
                alu_b  = imm_u;
                rd_we  = 1'b1;
            end
            OPC_AUIPC: begin
                alu_a = pc_q;
                alu_b = imm_u;
                rd_we = 1'b1;
            end
            OPC_JAL: begin
                is_jal = 1'b1;
                rd_we  = 1'b1;
                wb_sel = WB_PC4;
            end
            OPC_JALR: begin
                is_jalr = 1'b1;
                rd_we   = 1'b1;
                wb_sel  = WB_PC4;
            end
            OPC_BRANCH: is_branch = 1'b1;
            OPC_LOAD: begin
                // Reserved funct3 encodings fall through as NOPs.
                if (f3 == F3_B || f3 == F3_H || f3 == F3_W || f3 == F3_BU || f3 == F3_HU) begin
                    mem_req = 1'b1;
                    rd_we   = 1'b1;
                    wb_sel  = WB_LOAD;
                end
            end
            OPC_STORE: begin
                alu_b = imm_s;
                if (f3 == F3_B || f3 == F3_H || f3 == F3_W) begin
                    mem_req = 1'b1;
                    mem_we  = 1'b1;
                end
            end
            OPC_OP_IMM: begin
                alu_op = alu_op_from(f3, (f3 == F3_SR) && inst[30]);
                rd_we  = 1'b1;
            end
            OPC_OP: begin
                alu_b  = rs2_val;
                alu_op = alu_op_from(f3, inst[30]);
                rd_we  = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        alu_y = '0;
        case (alu_op)
            ALU_ADD:  alu_y = alu_a + alu_b;
            ALU_SUB:  alu_y = alu_a - alu_b;
            ALU_SLL:  alu_y = alu_a << alu_b[4:0];
            ALU_SLT:  alu_y = {31'd0, $signed(alu_a) < $signed(alu_b)};
            ALU_SLTU: alu_y = {31'd0, alu_a < alu_b};
            ALU_XOR:  alu_y = alu_a ^ alu_b;
            ALU_SRL:  alu_y = alu_a >> alu_b[4:0];
            ALU_SRA:  alu_y = $unsigned($signed(alu_a) >>> alu_b[4:0]);
            ALU_OR:   alu_y = alu_a | alu_b;
            ALU_AND:  alu_y = alu_a & alu_b;
            default:  alu_y = alu_b;
        endcase
    end

    always_comb begin
        br_taken = 1'b0;
        case (f3)
            F3_BEQ:  br_taken = (rs1_val == rs2_val);
            F3_BNE:  br_taken = (rs1_val != rs2_val);
            F3_BLT:  br_taken = ($signed(rs1_val) <  $signed(rs2_val));
            F3_BGE:  br_taken = ($signed(rs1_val) >= $signed(rs2_val));
            F3_BLTU: br_taken = (rs1_val <  rs2_val);
            F3_BGEU: br_taken = (rs1_val >= rs2_val);
            default: br_taken = 1'b0;
        endcase
    end

    always_comb begin
        next_pc = pc_plus4;
        if (is_jal) begin
            next_pc = pc_q + imm_j;
        end else if (is_jalr) begin
            next_pc = {alu_y[31:1], 1'b0};
        end else if (is_branch && br_taken) begin
            next_pc = pc_q + imm_b;
        end
    end

    // alu_y is the effective address for loads and stores; its low bits pick lanes.
    always_comb begin
        case (alu_y[1:0])
            2'd0:    ld_byte = dbus_data_i[7:0];
            2'd1:    ld_byte = dbus_data_i[15:8];
            2'd2:    ld_byte = dbus_data_i[23:16];
            default: ld_byte = dbus_data_i[31:24];
        endcase
        ld_half = alu_y[1] ? dbus_data_i[31:16] : dbus_data_i[15:0];
        case (f3)
            F3_B:    load_val = {{24{ld_byte[7]}}, ld_byte};
            F3_BU:   load_val = {24'd0, ld_byte};
            F3_H:    load_val = {{16{ld_half[15]}}, ld_half};
            F3_HU:   load_val = {16'd0, ld_half};
            default: load_val = dbus_data_i;
        endcase
    end

    always_comb begin
        case (f3)
            F3_B: begin
                st_sel  = 4'b0001 << alu_y[1:0];
                st_data = {4{rs2_val[7:0]}};
            end
            F3_H: begin
                st_sel  = 4'b0011 << {alu_y[1], 1'b0};
                st_data = {2{rs2_val[15:0]}};
            end
            default: begin
                st_sel  = 4'b1111;
                st_data = rs2_val;
            end
        endcase
    end

    always_comb begin
        case (wb_sel)
            WB_LOAD: wb_data = load_val;
            WB_PC4:  wb_data = pc_plus4;
            default: wb_data = alu_y;
        endcase
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= next_pc;
        end
    end

    // Buses have no handshake: req qualifies addr/sel/data for the current
    // cycle and the responder returns read data combinationally in that cycle.
    assign ibus_req_o  = ~rst_n;
    assign ibus_addr_o = pc_q;
    assign dbus_req_o  = mem_req & ~rst_n;
    assign dbus_we_o   = mem_we & ~rst_n;
    assign dbus_addr_o = {alu_y[31:2], 2'b00};
    assign dbus_sel_o  = rst_n ? 4'd0 : (mem_we ? st_sel : (mem_req ? 4'b1111 : 4'd0));
    assign dbus_data_o = (mem_we & ~rst_n) ? st_data : 32'd0;

endmodule

// File: tb/tb_riscv_ic_core.sv
// Bench for riscv_ic_core: runs a small program from a bench-side memory and
// compares every cycle's fetch address and data-bus activity with a queue.
module tb_riscv_ic_core;

    localparam logic [31:0] RPC = 32'h8000_0000;
    localparam int W = 102;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ibus_req_o;
    logic [31:0] ibus_addr_o;
    logic [31:0] ibus_data_i;
    logic        dbus_req_o;
    logic        dbus_we_o;
    logic [31:0] dbus_addr_o;
    logic [31:0] dbus_data_i;
    logic [31:0] dbus_data_o;
    logic [3:0]  dbus_sel_o;
    logic [7:0]  int_i;

    logic [31:0] imem [0:127];
    logic [W-1:0] exp_q[$];
    int n_checks = 0;
    int n_errors = 0;

    riscv_ic_core #(.RESET_PC(RPC)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ibus_req_o  (ibus_req_o),
        .ibus_addr_o (ibus_addr_o),
        .ibus_data_i (ibus_data_i),
        .dbus_req_o  (dbus_req_o),
        .dbus_we_o   (dbus_we_o),
        .dbus_addr_o (dbus_addr_o),
        .dbus_data_i (dbus_data_i),
        .dbus_data_o (dbus_data_o),
        .dbus_sel_o  (dbus_sel_o),
        .int_i       (int_i)
    );

    // clock / memories
    always #5 clk = ~clk;
    assign ibus_data_i = imem[ibus_addr_o[8:2]];
    assign dbus_data_i = 32'h80FF_0000;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // instruction encoders
    function automatic logic [31:0] enc_i(input logic [31:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
        return {imm[11:0], rs1, f3, rd, op};
    endfunction
    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction
    function automatic logic [31:0] enc_s(input logic [31:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
    endfunction
    function automatic logic [31:0] enc_b(input logic [31:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction
    function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd, input logic [6:0] op);
        return {imm, rd, op};
    endfunction
    function automatic logic [31:0] enc_j(input logic [31:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
    endfunction

    task automatic put(input int off, input logic [31:0] word);
        imem[off >> 2] = word;
    endtask

    // driver tasks: expected bus activity per executed instruction
    task automatic exp_nop(input int off);
        exp_q.push_back({RPC + 32'(off), 1'b0, 1'b0, 32'd0, 4'd0, 32'd0});
    endtask
    task automatic exp_st(input int off, input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
        exp_q.push_back({RPC + 32'(off), 1'b1, 1'b1, a, s, d});
    endtask
    task automatic exp_ld(input int off, input logic [31:0] a);
        exp_q.push_back({RPC + 32'(off), 1'b1, 1'b0, a, 4'b1111, 32'd0});
    endtask

    task automatic load_program();
        for (int i = 0; i < 128; i++) imem[i] = 32'h0000_0013;
        put('h00, enc_i(5, 0, 3'b000, 1, 7'b0010011));           // addi x1,x0,5
        put('h04, enc_i(-7, 1, 3'b000, 2, 7'b0010011));          // addi x2,x1,-7
        put('h08, enc_r(7'b0100000, 2, 1, 3'b000, 3));           // sub x3,x1,x2
        put('h0C, enc_u(20'h80000, 5, 7'b0110111));              // lui x5
        put('h10, enc_s(8, 3, 5, 3'b010));                       // sw x3,8(x5)
        put('h14, enc_s(0, 2, 5, 3'b010));                       // sw x2,0(x5)
        put('h18, enc_u(20'h12345, 6, 7'b0110111));              // lui x6
        put('h1C, enc_i(32'h6AB, 6, 3'b000, 6, 7'b0010011));     // addi x6,x6,0x6ab
        put('h20, enc_s(3, 6, 5, 3'b000));                       // sb x6,3(x5)
        put('h24, enc_s(2, 6, 5, 3'b001));                       // sh x6,2(x5)
        put('h28, enc_i(3, 5, 3'b000, 7, 7'b0000011));           // lb x7,3(x5)
        put('h2C, enc_i(3, 5, 3'b100, 8, 7'b0000011));           // lbu x8,3(x5)
        put('h30, enc_s(4, 7, 5, 3'b010));
        put('h34, enc_s(4, 8, 5, 3'b010));
        put('h38, enc_i(2, 5, 3'b001, 9, 7'b0000011));           // lh x9,2(x5)
        put('h3C, enc_s(0, 9, 5, 3'b010));
        put('h40, enc_r(7'd0, 1, 2, 3'b010, 10));                // slt x10,x2,x1
        put('h44, enc_r(7'd0, 1, 2, 3'b011, 11));                // sltu x11,x2,x1
        put('h48, enc_i(32'h401, 2, 3'b101, 12, 7'b0010011));    // srai x12,x2,1
        put('h4C, enc_i(4, 2, 3'b101, 13, 7'b0010011));          // srli x13,x2,4
        put('h50, enc_s(0, 10, 5, 3'b010));
        put('h54, enc_s(0, 11, 5, 3'b010));
        put('h58, enc_s(0, 12, 5, 3'b010));
        put('h5C, enc_s(0, 13, 5, 3'b010));
        put('h60, enc_b(8, 0, 0, 3'b000));                       // beq taken +8
        put('h64, enc_i(99, 0, 3'b000, 14, 7'b0010011));         // skipped
        put('h68, enc_b(8, 1, 1, 3'b001));                       // bne not taken
        put('h6C, enc_i(1, 0, 3'b000, 0, 7'b0010011));           // addi x0,x0,1
        put('h70, enc_s(0, 0, 5, 3'b010));
        put('h74, enc_j(12, 15));                                // jal x15,+12
        put('h78, 32'h0000_0073);
        put('h7C, 32'h0000_0073);
        put('h80, enc_s(0, 15, 5, 3'b010));
        put('h84, enc_i(32'h100, 5, 3'b000, 16, 7'b0010011));    // addi x16,x5,0x100
        put('h88, enc_i(3, 16, 3'b000, 17, 7'b1100111));         // jalr x17,3(x16)
        put('h100, enc_s(0, 17, 5, 3'b010));
        put('h104, enc_s(0, 16, 5, 3'b010));
        put('h108, 32'h0000_000F);                               // fence
        put('h10C, 32'h0000_0073);                               // ecall
        put('h110, enc_s(0, 14, 5, 3'b010));
        put('h114, enc_b(-8, 0, 0, 3'b000));                     // beq -8
    endtask

    task automatic fill_expected();
        for (int o = 'h00; o <= 'h0C; o += 4) exp_nop(o);
        exp_st('h10, 32'h8000_0008, 4'hF, 32'h0000_0007);
        exp_st('h14, 32'h8000_0000, 4'hF, 32'hFFFF_FFFE);
        exp_nop('h18); exp_nop('h1C);
        exp_st('h20, 32'h8000_0000, 4'b1000, 32'hABAB_ABAB);
        exp_st('h24, 32'h8000_0000, 4'b1100, 32'h56AB_56AB);
        exp_ld('h28, 32'h8000_0000);
        exp_ld('h2C, 32'h8000_0000);
        exp_st('h30, 32'h8000_0004, 4'hF, 32'hFFFF_FF80);
        exp_st('h34, 32'h8000_0004, 4'hF, 32'h0000_0080);
        exp_ld('h38, 32'h8000_0000);
        exp_st('h3C, 32'h8000_0000, 4'hF, 32'hFFFF_80FF);
        for (int o = 'h40; o <= 'h4C; o += 4) exp_nop(o);
        exp_st('h50, 32'h8000_0000, 4'hF, 32'h0000_0001);
        exp_st('h54, 32'h8000_0000, 4'hF, 32'h0000_0000);
        exp_st('h58, 32'h8000_0000, 4'hF, 32'hFFFF_FFFF);
        exp_st('h5C, 32'h8000_0000, 4'hF, 32'h0FFF_FFFF);
        exp_nop('h60); exp_nop('h68); exp_nop('h6C);
        exp_st('h70, 32'h8000_0000, 4'hF, 32'h0000_0000);
        exp_nop('h74);
        exp_st('h80, 32'h8000_0000, 4'hF, 32'h8000_0078);
        exp_nop('h84); exp_nop('h88);
        exp_st('h102, 32'h8000_0000, 4'hF, 32'h8000_008C);
        exp_st('h106, 32'h8000_0000, 4'hF, 32'h8000_0100);
        exp_nop('h10A);
        for (int k = 0; k < 2; k++) begin
            exp_nop('h10E);
            exp_st('h112, 32'h8000_0000, 4'hF, 32'h0000_0000);
            exp_nop('h116);
        end
    endtask

    // scoreboard: pop one entry per retired instruction
    task automatic drain_queue();
        logic [W-1:0] e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            int_i = 8'($urandom_range(0, 255));
            check_eq("ibus_addr", ibus_addr_o, e[101:70]);
            check_eq("ibus_req", 32'(ibus_req_o), 32'd1);
            check_eq("dbus_req", 32'(dbus_req_o), 32'(e[69]));
            check_eq("dbus_we", 32'(dbus_we_o), 32'(e[68]));
            check_eq("dbus_sel", 32'(dbus_sel_o), 32'(e[35:32]));
            if (e[69]) check_eq("dbus_addr", dbus_addr_o, e[67:36]);
            if (e[68]) check_eq("dbus_data", dbus_data_o, e[31:0]);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_pc"}, ibus_addr_o, RPC);
        check_eq({tag, "_ireq"}, 32'(ibus_req_o), 32'd0);
        check_eq({tag, "_dreq"}, 32'(dbus_req_o), 32'd0);
        check_eq({tag, "_we"}, 32'(dbus_we_o), 32'd0);
        check_eq({tag, "_sel"}, 32'(dbus_sel_o), 32'd0);
        check_eq({tag, "_data"}, dbus_data_o, 32'd0);
    endtask

    initial begin
        rst_n = 1'b1;
        int_i = 8'd0;
        load_program();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");

        fill_expected();
        rst_n = 1'b0;
        #1;
        drain_queue();

        // Asynchronous reset mid-cycle: PC must snap back immediately.
        #2;
        rst_n = 1'b1;
        #1;
        check_reset_outputs("midreset");
        @(negedge clk);
        rst_n = 1'b0;
        for (int o = 'h00; o <= 'h0C; o += 4) exp_nop(o);
        exp_st('h10, 32'h8000_0008, 4'hF, 32'h0000_0007);
        #1;
        drain_queue();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/riscv_ic_core.md
# riscv_ic_core

Single-cycle RV32I integer core: fetches one instruction per clock over a combinational instruction bus, executes it and retires it on the next rising edge. Sits under the SoC top, which drives both buses from a combinational memory model. No caches, no pipeline, no CSRs; interrupts are reserved.

## Interface
- Parameters
  - RESET_PC, 32'h8000_0000, PC value after reset.
- Ports
  - clk  in  1  system clock; all state updates on the rising edge.
  - rst_n  in  1  reset; one clock; reset is asynchronous and active-high (the `_n` suffix is the codebase port name only, not the polarity).
  - ibus_req_o  out  1  instruction fetch request.
  - ibus_addr_o  out  32  fetch byte address (equals PC).
  - ibus_data_i  in  32  instruction word, valid in the same cycle.
  - dbus_req_o  out  1  data access request (load or store).
  - dbus_we_o  out  1  1 = store.
  - dbus_addr_o  out  32  data byte address, word-aligned (`{addr[31:2],2'b00}`).
  - dbus_data_i  in  32  read word, valid in the same cycle.
  - dbus_data_o  out  32  store data, placed in byte lanes.
  - dbus_sel_o  out  4  byte-lane enables; bit n = byte n.
  - int_i  in  8  reserved; ignored, may be left unconnected.

## Operation
- Executes all RV32I instructions: LUI, AUIPC, JAL, JALR, branches, loads, stores, OP-IMM, OP.
- FENCE, ECALL, EBREAK and undecodable opcodes execute as NOPs (PC+4, no writes).
- Register file: 32×32, x0 reads 0, writes to x0 discarded.
- Next PC: PC+4; JAL PC+imm; JALR (rs1+imm)&~1; taken branch PC+imm. Address arithmetic is modulo 2^32; no misalignment traps.
- Effective address ea = rs1+imm.
  - Loads: LB/LBU use byte ea[1:0]; LH/LHU use halfword ea[1]; LW the full word. Sign- or zero-extend accordingly.
  - Stores: SB sel=4'b0001<<ea[1:0], data = rs2[7:0] replicated to all lanes. SH sel=4'b0011<<{ea[1],1'b0}, data = rs2[15:0] replicated. SW sel=4'b1111.
- Misaligned halfword/word: the low address bits select lanes as above; no fault is raised.
- dbus_req_o=1 only for loads and stores. dbus_we_o=1 only for stores. dbus_sel_o=4'b1111 on loads and 0 when idle.
- Shifts use rs2[4:0] or shamt. SLT/SLTU are signed/unsigned compares. SRA/SRAI are arithmetic shifts.

## Timing
- Fetch, decode, execute and memory access are combinational within one cycle. PC and the register write commit on the rising edge: one instruction per clock, latency 1.
- The load result is written to rd at the end of the same cycle.
- During reset: PC=RESET_PC, ibus_req_o=0, dbus_req_o=0, dbus_we_o=0, dbus_sel_o=0, dbus_data_o=0. Registers x1..x31 clear to 0.
- First fetch is at RESET_PC in the first cycle after reset deassertion. Reset asserted mid-instruction aborts it: no register write, and PC returns to RESET_PC immediately.
- Bus outputs are combinational from PC and registers. Memory must sample stores at the clock edge or tolerate settling.

## Structure
- Package riscv_pkg:
  - opcode/funct3/funct7 constants;
  - bus widths (InstAddrBus, InstBus, MemAddrBus, MemBus = 32);
  - RESET_PC default;
  - ALU op enum.
- Sub-module riscv_regfile: 2 async read ports, 1 sync write port, x0 hardwired, async reset.
- Decode, ALU, branch compare and load/store lane logic live in the top-level core.

## Test plan
- Reset release -> ibus_addr_o=0x8000_0000 in the first cycle, then 0x8000_0004 in the next.
- `addi x1,x0,5`; `addi x2,x1,-7`; `sub x3,x1,x2` -> x2=0xFFFF_FFFE, x3=7.
- `lui x5,0x80000`; `sw x3,8(x5)` -> dbus_req_o=1, we=1, addr=0x8000_0008, sel=4'b1111, data=7.
- `sb` with x6=0x1234_56AB at address 0x8000_0003 -> addr=0x8000_0000, sel=4'b1000, data=0xABAB_ABAB.
- `lb`/`lbu` at offset 3 with dbus_data_i=0x80FF_0000 -> lb gives 0xFFFF_FF80, lbu gives 0x0000_0080.
- Branches and jumps:
  - `beq` taken with imm=-8 at PC 0x8000_0010 -> next PC 0x8000_0008.
  - `jalr x1,3(x2)` with x2=0x8000_0100 -> PC 0x8000_0102, x1=PC+4.
  - `addi x0,x0,1` leaves x0=0.
